// File: rtl/ex_stage_if.sv
// Execute-stage port bundle: decoded operands and controls in,
// writeback value, redirect and stall out.
interface ex_stage_if #(
    parameter int XLEN = 32
);
    logic            valid_in;
    logic            flush;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [XLEN-1:0] immd;
    logic            sel_alu_src;
    logic [3:0]      alu_op;
    logic            md_en;
    logic [2:0]      md_op;
    logic            branch;
    logic [2:0]      br_cond;
    logic            jump;
    logic            jalr;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            stall;

    modport master (
        output valid_in, flush, pc, rdata1, rdata2, immd,
        output sel_alu_src, alu_op, md_en, md_op,
        output branch, br_cond, jump, jalr,
        input  result, store_data, branch_taken,
        input  branch_target, stall
    );

    modport slave (
        input  valid_in, flush, pc, rdata1, rdata2, immd,
        input  sel_alu_src, alu_op, md_en, md_op,
        input  branch, br_cond, jump, jalr,
        output result, store_data, branch_taken,
        output branch_target, stall
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU and branch resolution,
// iterative one-bit-per-cycle RV32M multiply/divide.
module ex_stage #(
    parameter int XLEN     = 32,
    parameter int MD_STEPS = 32
) (
    input logic     clk,
    input logic     rst,
    ex_stage_if.slave ex
);

    localparam int SW = $clog2(XLEN);
    localparam int CW = $clog2(MD_STEPS) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } md_state_e;

    md_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   op_q, op_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic [1:0]        mdop_q, mdop_d;
    logic [XLEN-1:0]   md_result_q, md_result_d;

    logic            live;
    logic [XLEN-1:0] b_op;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] alu_res;
    logic            eq, lt_s, lt_u, cond;

    assign live = ex.valid_in & ~ex.flush;
    assign b_op = ex.sel_alu_src ? ex.immd : ex.rdata2;
    assign shamt = b_op[SW-1:0];
    assign eq = ex.rdata1 == ex.rdata2;
    assign lt_s = $signed(ex.rdata1) < $signed(ex.rdata2);
    assign lt_u = ex.rdata1 < ex.rdata2;

    always_comb begin
        alu_res = '0;
        unique case (ex.alu_op)
            4'd0:    alu_res = ex.rdata1 + b_op;
            4'd1:    alu_res = ex.rdata1 - b_op;
            4'd2:    alu_res = ex.rdata1 << shamt;
            4'd3:    alu_res = {{(XLEN-1){1'b0}}, $signed(ex.rdata1) < $signed(b_op)};
            4'd4:    alu_res = {{(XLEN-1){1'b0}}, ex.rdata1 < b_op};
            4'd5:    alu_res = ex.rdata1 ^ b_op;
            4'd6:    alu_res = ex.rdata1 >> shamt;
            4'd7:    alu_res = $unsigned($signed(ex.rdata1) >>> shamt);
            4'd8:    alu_res = ex.rdata1 | b_op;
            4'd9:    alu_res = ex.rdata1 & b_op;
            4'd10:   alu_res = b_op;
            4'd11:   alu_res = ex.pc + b_op;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        unique case (ex.br_cond)
            3'd0:    cond = eq;
            3'd1:    cond = ~eq;
            3'd4:    cond = lt_s;
            3'd5:    cond = ~lt_s;
            3'd6:    cond = lt_u;
            3'd7:    cond = ~lt_u;
            default: cond = 1'b0;
        endcase
    end

    assign ex.branch_taken = live & ((ex.branch & cond) | ex.jump);
    assign ex.branch_target = ex.jalr
        ? ((ex.rdata1 + ex.immd) & ~XLEN'(1))
        : (ex.pc + ex.immd);
    assign ex.store_data = ex.rdata2;
    assign ex.stall = ~rst & live & ex.md_en & (state_q != S_DONE);

    always_comb begin
        ex.result = '0;
        if (live) begin
            if (ex.jump)
                ex.result = ex.pc + XLEN'(4);
            else if (ex.md_en)
                ex.result = (state_q == S_DONE) ? md_result_q : '0;
            else if (!ex.branch)
                ex.result = alu_res;
        end
    end

    // Operand sign handling: signed-ness of A and B per funct3
    logic            a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div0, ovf;

    always_comb begin
        if (ex.md_op[2]) begin
            a_sgn = ~ex.md_op[0];
            b_sgn = ~ex.md_op[0];
        end else begin
            a_sgn = ex.md_op[1:0] != 2'b11;
            b_sgn = ~ex.md_op[1];
        end
        a_neg = a_sgn & ex.rdata1[XLEN-1];
        b_neg = b_sgn & ex.rdata2[XLEN-1];
        abs_a = a_neg ? (~ex.rdata1 + XLEN'(1)) : ex.rdata1;
        abs_b = b_neg ? (~ex.rdata2 + XLEN'(1)) : ex.rdata2;
        div0 = ex.rdata2 == '0;
        ovf = a_sgn & (ex.rdata1 == MIN_NEG) & (ex.rdata2 == '1);
    end

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, mul_fin;
    logic [XLEN:0]     div_sh, div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   quo, rem;
    logic              last;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
                + (acc_q[0] ? {1'b0, op_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        mul_fin = neg_q ? (~mul_next + (2*XLEN)'(1)) : mul_next;
        // Restoring step: shift in next dividend bit, subtract if it fits
        div_sh = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff = div_sh - {1'b0, op_q};
        if (div_diff[XLEN])
            div_next = {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        else
            div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        quo = div_next[XLEN-1:0];
        rem = div_next[2*XLEN-1:XLEN];
        if (neg_q)
            quo = ~quo + XLEN'(1);
        if (rneg_q)
            rem = ~rem + XLEN'(1);
        last = cnt_q == CW'(MD_STEPS - 1);
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        op_d = op_q;
        neg_d = neg_q;
        rneg_d = rneg_q;
        mdop_d = mdop_q;
        md_result_d = md_result_q;
        unique case (state_q)
            S_IDLE: begin
                if (live && ex.md_en) begin
                    cnt_d = '0;
                    mdop_d = ex.md_op[1:0];
                    neg_d = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    if (!ex.md_op[2]) begin
                        acc_d = {{XLEN{1'b0}}, abs_b};
                        op_d = abs_a;
                        state_d = S_MUL;
                    end else if (div0) begin
                        md_result_d = ex.md_op[1] ? ex.rdata1 : '1;
                        state_d = S_DONE;
                    end else if (ovf) begin
                        md_result_d = ex.md_op[1] ? '0 : MIN_NEG;
                        state_d = S_DONE;
                    end else begin
                        acc_d = {{XLEN{1'b0}}, abs_a};
                        op_d = abs_b;
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                if (ex.flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = mul_next;
                    cnt_d = cnt_q + CW'(1);
                    if (last) begin
                        md_result_d = (mdop_q == 2'b00)
                            ? mul_fin[XLEN-1:0]
                            : mul_fin[2*XLEN-1:XLEN];
                        state_d = S_DONE;
                    end
                end
            end
            S_DIV: begin
                if (ex.flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = div_next;
                    cnt_d = cnt_q + CW'(1);
                    if (last) begin
                        md_result_d = mdop_q[1] ? rem : quo;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q <= '0;
            acc_q <= '0;
            op_q <= '0;
            neg_q <= 1'b0;
            rneg_q <= 1'b0;
            mdop_q <= '0;
            md_result_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            op_q <= op_d;
            neg_q <= neg_d;
            rneg_q <= rneg_d;
            mdop_q <= mdop_d;
            md_result_q <= md_result_d;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU, branches, jumps,
// iterative mul/div latency and results, flush and reset aborts.
module tb_ex_stage;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    ex_stage_if #(.XLEN(32)) ex ();

    ex_stage #(.XLEN(32), .MD_STEPS(32)) dut (
        .clk(clk),
        .rst(rst),
        .ex (ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ex.valid_in = 1'b0;
        ex.flush = 1'b0;
        ex.pc = '0;
        ex.rdata1 = '0;
        ex.rdata2 = '0;
        ex.immd = '0;
        ex.sel_alu_src = 1'b0;
        ex.alu_op = 4'd0;
        ex.md_en = 1'b0;
        ex.md_op = 3'd0;
        ex.branch = 1'b0;
        ex.br_cond = 3'd0;
        ex.jump = 1'b0;
        ex.jalr = 1'b0;
    endtask

    task automatic alu(input string tag, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic sel, input logic [31:0] imm,
                       input logic [31:0] exp);
        clr();
        ex.valid_in = 1'b1;
        ex.alu_op = op;
        ex.rdata1 = a;
        ex.rdata2 = b;
        ex.sel_alu_src = sel;
        ex.immd = imm;
        ex.pc = 32'h100;
        @(negedge clk);
        chk(tag, ex.result, exp);
        chk({tag, "_stall"}, {31'b0, ex.stall}, 32'd0);
        tick();
    endtask

    task automatic run_md(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_stalls, input logic [31:0] exp);
        int  n;
        bit  done;
        clr();
        ex.valid_in = 1'b1;
        ex.md_en = 1'b1;
        ex.md_op = op;
        ex.rdata1 = a;
        ex.rdata2 = b;
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!ex.stall) begin
                done = 1'b1;
            end else begin
                n++;
                tick();
            end
        end
        chk({tag, "_stalls"}, 32'(n), 32'(exp_stalls));
        chk(tag, ex.result, exp);
        tick();
        clr();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clr();
        rst = 1'b1;
        ex.valid_in = 1'b1;
        ex.md_en = 1'b1;
        ex.md_op = 3'd0;
        #2;
        @(negedge clk);
        chk("rst_stall", {31'b0, ex.stall}, 32'd0);
        chk("rst_result", ex.result, 32'd0);
        clr();
        @(negedge clk);
        rst = 1'b0;
        tick();

        alu("add_imm", 4'd0, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
        alu("sub", 4'd1, 32'd0, 32'd1, 1'b0, 32'd0, 32'hFFFF_FFFF);
        alu("sll", 4'd2, 32'd1, 32'h3F, 1'b0, 32'd0, 32'h8000_0000);
        alu("slt", 4'd3, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 32'd1);
        alu("sltu", 4'd4, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd1);
        alu("sra", 4'd7, 32'h8000_0000, 32'd4, 1'b0, 32'd0, 32'hF800_0000);
        alu("srl", 4'd6, 32'h8000_0000, 32'd4, 1'b0, 32'd0, 32'h0800_0000);
        alu("xor", 4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'd0, 32'h0FF0_0FF0);
        alu("pcb", 4'd11, 32'd0, 32'd0, 1'b1, 32'h1000, 32'h1100);

        clr();
        ex.valid_in = 1'b1;
        ex.branch = 1'b1;
        ex.br_cond = 3'd4;
        ex.rdata1 = 32'hFFFF_FFFF;
        ex.rdata2 = 32'd1;
        ex.pc = 32'h100;
        ex.immd = 32'h20;
        @(negedge clk);
        chk("blt_taken", {31'b0, ex.branch_taken}, 32'd1);
        chk("blt_target", ex.branch_target, 32'h120);
        tick();
        ex.rdata1 = 32'd1;
        ex.rdata2 = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("blt_swap", {31'b0, ex.branch_taken}, 32'd0);
        tick();
        ex.br_cond = 3'd6;
        @(negedge clk);
        chk("bltu", {31'b0, ex.branch_taken}, 32'd1);
        tick();

        clr();
        ex.valid_in = 1'b1;
        ex.jump = 1'b1;
        ex.pc = 32'h200;
        ex.immd = 32'h10;
        @(negedge clk);
        chk("jal_taken", {31'b0, ex.branch_taken}, 32'd1);
        chk("jal_target", ex.branch_target, 32'h210);
        chk("jal_link", ex.result, 32'h204);
        tick();
        ex.jalr = 1'b1;
        ex.rdata1 = 32'h1001;
        ex.immd = 32'd4;
        @(negedge clk);
        chk("jalr_target", ex.branch_target, 32'h1004);
        tick();
        ex.flush = 1'b1;
        @(negedge clk);
        chk("flush_jump", {31'b0, ex.branch_taken}, 32'd0);
        chk("flush_result", ex.result, 32'd0);
        tick();
        ex.flush = 1'b0;
        ex.valid_in = 1'b0;
        @(negedge clk);
        chk("bubble_jump", {31'b0, ex.branch_taken}, 32'd0);
        tick();

        run_md("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000);
        run_md("mul", 3'd0, 32'h8000_0000, 32'h8000_0000, 33, 32'd0);
        run_md("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE);
        run_md("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
        run_md("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
        run_md("divu0", 3'd5, 32'd1234, 32'd0, 1, 32'hFFFF_FFFF);
        run_md("remu0", 3'd7, 32'd9, 32'd0, 1, 32'd9);
        run_md("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
        run_md("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);

        clr();
        ex.valid_in = 1'b1;
        ex.md_en = 1'b1;
        ex.md_op = 3'd5;
        ex.rdata1 = 32'd100;
        ex.rdata2 = 32'd7;
        repeat (9) tick();
        @(negedge clk);
        chk("divu_busy", {31'b0, ex.stall}, 32'd1);
        #1;
        ex.flush = 1'b1;
        #1;
        chk("flush_stall", {31'b0, ex.stall}, 32'd0);
        chk("flush_md_res", ex.result, 32'd0);
        tick();
        alu("add_after", 4'd0, 32'd40, 32'd2, 1'b0, 32'd0, 32'd42);
        run_md("divu_rerun", 3'd5, 32'd100, 32'd7, 33, 32'd14);

        clr();
        ex.valid_in = 1'b1;
        ex.md_en = 1'b1;
        ex.md_op = 3'd0;
        ex.rdata1 = 32'd3;
        ex.rdata2 = 32'd4;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_stall", {31'b0, ex.stall}, 32'd0);
        tick();
        rst = 1'b0;
        run_md("mul_restart", 3'd0, 32'd3, 32'd4, 33, 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
